// File: rtl/tc_adc_sampler.sv
// tc_adc_sampler: periodic 16-SCLK read of a 10-bit serial ADC feeding tc_calc.
// Define TC_ADC_AVG_EN to emit the mean of every four good frames instead.
module tc_adc_sampler #(
  parameter int unsigned CLK_DIV       = 4,
  parameter int unsigned SAMPLE_PERIOD = 100000,
  parameter int unsigned CS_SETUP      = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_enable,
  input  logic       i_miso,
  output logic       o_sclk,
  output logic       o_cs_n,
  output logic [9:0] o_code,
  output logic       o_start,
  output logic       o_err,
  output logic       o_busy
);

  localparam int unsigned TW = $clog2(SAMPLE_PERIOD);
  localparam int unsigned DW = $clog2(CLK_DIV + 1);
  localparam int unsigned CW = $clog2(CS_SETUP + 1);

  localparam logic [TW-1:0] T_MAX = TW'(SAMPLE_PERIOD - 1);
  localparam logic [DW-1:0] D_MAX = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] C_MAX = CW'(CS_SETUP - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    bit_q, bit_d;
  logic [15:0]   sr_q, sr_d;
  logic          sclk_q, sclk_d;
  logic          cs_n_q, cs_n_d;
  logic          busy_q, busy_d;
  logic [9:0]    code_q, code_d;
  logic          start_q, start_d;
  logic          err_q, err_d;
  logic          frame_ok;
  logic [9:0]    data;
`ifdef TC_ADC_AVG_EN
  logic [11:0]   sum_q, sum_d;
  logic [1:0]    acc_q, acc_d;
  logic [11:0]   sum_all;
`endif

  assign frame_ok = (sr_q[15:13] == 3'b000) && (sr_q[2:0] == 3'b000);
  assign data     = sr_q[12:3];

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sr_d    = sr_q;
    sclk_d  = sclk_q;
    cs_n_d  = cs_n_q;
    busy_d  = busy_q;
    code_d  = code_q;
    start_d = 1'b0;
    err_d   = 1'b0;
`ifdef TC_ADC_AVG_EN
    sum_d   = sum_q;
    acc_d   = acc_q;
    sum_all = sum_q + {2'b00, data};
`endif

    if (timer_q != T_MAX) begin
      timer_d = timer_q + 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (timer_q == T_MAX && i_enable) begin
          timer_d = '0;
          cnt_d   = '0;
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_q == C_MAX) begin
          sclk_d  = 1'b0;
          div_d   = '0;
          bit_d   = '0;
          state_d = S_SHIFT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SHIFT: begin
        if (div_q == D_MAX) begin
          div_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
            sr_d   = {sr_q[14:0], i_miso};
            bit_d  = bit_q + 1'b1;
          end else if (bit_q == 5'd16) begin
            // last period's high half is done; SCLK parks high
            cnt_d   = '0;
            state_d = S_HOLD;
          end else begin
            sclk_d = 1'b0;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt_q == C_MAX) begin
          cs_n_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
          if (frame_ok) begin
`ifdef TC_ADC_AVG_EN
            if (acc_q == 2'd3) begin
              code_d  = sum_all[11:2];
              start_d = 1'b1;
              sum_d   = '0;
              acc_d   = '0;
            end else begin
              sum_d = sum_all;
              acc_d = acc_q + 1'b1;
            end
`else
            code_d  = data;
            start_d = 1'b1;
`endif
          end else begin
            err_d = 1'b1;
`ifdef TC_ADC_AVG_EN
            sum_d = '0;
            acc_d = '0;
`endif
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      sclk_q  <= 1'b1;
      cs_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      code_q  <= '0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
`ifdef TC_ADC_AVG_EN
      sum_q   <= '0;
      acc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
      busy_q  <= busy_d;
      code_q  <= code_d;
      start_q <= start_d;
      err_q   <= err_d;
`ifdef TC_ADC_AVG_EN
      sum_q   <= sum_d;
      acc_q   <= acc_d;
`endif
    end
  end

  assign o_sclk  = sclk_q;
  assign o_cs_n  = cs_n_q;
  assign o_code  = code_q;
  assign o_start = start_q;
  assign o_err   = err_q;
  assign o_busy  = busy_q;

endmodule

// File: tb/tb_tc_adc_sampler.sv
// tb_tc_adc_sampler: ADC frame model plus cycle model of tc_adc_sampler.
// Honours TC_ADC_AVG_EN to select the averaging scenario.
module tb_tc_adc_sampler;

  localparam int DIV   = 4;
  localparam int SP    = 200;
  localparam int CSS   = 2;
  localparam int FRAME = 2 * CSS + 32 * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic       miso = 1'b0;
  logic       sclk, cs_n, start, err, busy;
  logic [9:0] code;

  tc_adc_sampler #(
    .CLK_DIV(DIV),
    .SAMPLE_PERIOD(SP),
    .CS_SETUP(CSS)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_enable(en),
    .i_miso(miso),
    .o_sclk(sclk),
    .o_cs_n(cs_n),
    .o_code(code),
    .o_start(start),
    .o_err(err),
    .o_busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // ADC: loads a frame at CS fall, shifts MSB first on each SCLK fall
  logic [15:0] frame_q[$];
  logic [15:0] cur_frame = 16'hFFFF;
  int          k = 0;

  always @(negedge cs_n) begin
    cur_frame = (frame_q.size() > 0) ? frame_q.pop_front() : 16'hFFFF;
    k = 0;
  end

  always @(negedge sclk) begin
    if (cs_n === 1'b0 && k < 16) begin
      miso = cur_frame[15-k];
      k++;
    end
  end

  // model state and observations
  int  n = 0;
  bit  en_p = 1'b1;
  bit  rst_p = 1'b1;
  bit  in_f = 1'b0;
  int  fall_n = 0;
  int  last_n = 0;
  int  rst_edge = 0;
  int  m_code = 0;
  int  good_q[$];
  int  fall_obs = -1;
  int  rise_obs = -1;
  int  starts = 0;
  int  errs = 0;
  int  start_n = -1;
  int  last_code = 0;
  int  sclk_rises = 0;
  int  falls_q[$];
  int  rises_q[$];
  bit  sclk_p = 1'b1;
  bit  cs_p = 1'b1;

  always @(negedge clk) begin
    logic [15:0] f;
    int t;
    bit m_start;
    bit m_err;
    bit m_sclk;
    n++;
    m_start = 1'b0;
    m_err = 1'b0;
    if (rst_p) begin
      in_f = 1'b0;
      m_code = 0;
      last_n = n;
      rst_edge = n;
      good_q.delete();
    end else if (in_f && (n - fall_n) == FRAME) begin
      in_f = 1'b0;
      f = cur_frame;
      if (f[15:13] == 3'b000 && f[2:0] == 3'b000) begin
`ifdef TC_ADC_AVG_EN
        good_q.push_back(int'(f[12:3]));
        if (good_q.size() == 4) begin
          m_code = (good_q[0] + good_q[1] + good_q[2] + good_q[3]) / 4;
          m_start = 1'b1;
          good_q.delete();
        end
`else
        m_code = int'(f[12:3]);
        m_start = 1'b1;
`endif
      end else begin
        m_err = 1'b1;
        good_q.delete();
      end
    end else if (!in_f && (n - last_n) >= SP && en_p) begin
      in_f = 1'b1;
      fall_n = n;
      last_n = n;
    end
    t = n - fall_n;
    m_sclk = !(in_f && t >= CSS && t < CSS + 32 * DIV &&
               ((t - CSS) / DIV) % 2 == 0);
    chk("outputs", {cs_n, sclk, busy, start, err, code},
        {!in_f, m_sclk, in_f, m_start, m_err, 10'(m_code)});

    if (cs_p && !cs_n) begin
      fall_obs = n;
      falls_q.push_back(n);
      sclk_rises = 0;
    end
    if (!sclk_p && sclk && !cs_n) sclk_rises++;
    if (!cs_p && cs_n) begin
      rise_obs = n;
      rises_q.push_back(sclk_rises);
    end
    if (start) begin
      starts++;
      start_n = n;
      last_code = int'(code);
    end
    if (err) errs++;
    cs_p = cs_n;
    sclk_p = sclk;
    en_p = en;
    rst_p = rst;
  end

  task automatic tick(input int c);
    repeat (c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_done(input string nm);
    int r0;
    int i;
    r0 = rise_obs;
    i = 0;
    while (rise_obs == r0 && i < 3 * SP) begin
      tick(1);
      i++;
    end
    chk({nm, "_done"}, 32'(rise_obs != r0), 32'd1);
  endtask

  task automatic do_frame(input logic [15:0] f, input string nm);
    frame_q.push_back(f);
    wait_done(nm);
  endtask

  initial begin
    int s0;
    int e0;
    int fe;
    int i;

    tick(3);
    chk("rst_cs_n", 32'(cs_n), 32'd1);
    chk("rst_sclk", 32'(sclk), 32'd1);
    chk("rst_code", 32'(code), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_strobes", 32'({start, err}), 32'd0);
    rst = 1'b0;

`ifdef TC_ADC_AVG_EN
    do_frame(16'(100 << 3), "v0");
    do_frame(16'(101 << 3), "v1");
    do_frame(16'(102 << 3), "v2");
    chk("avg_none_yet", 32'(starts), 32'd0);
    do_frame(16'(103 << 3), "v3");
    chk("avg_one_start", 32'(starts), 32'd1);
    chk("avg_code", 32'(last_code), 32'd101);
    do_frame(16'(200 << 3), "w0");
    do_frame(16'(200 << 3), "w1");
    do_frame(16'hFFFF, "werr");
    chk("avg_err", 32'(errs), 32'd1);
    do_frame(16'(8 << 3), "x0");
    do_frame(16'(8 << 3), "x1");
    do_frame(16'(8 << 3), "x2");
    chk("avg_reset_cnt", 32'(starts), 32'd1);
    do_frame(16'(12 << 3), "x3");
    chk("avg_two_start", 32'(starts), 32'd2);
    chk("avg_code2", 32'(last_code), 32'd9);
`else
    // single good frame, default timing
    do_frame(16'h1528, "a");
    chk("a_first_fall", 32'(fall_obs - rst_edge), 32'(SP));
    chk("a_cs_low", 32'(rise_obs - fall_obs), 32'd132);
    chk("a_code", 32'(last_code), 32'd677);
    chk("a_start_edge", 32'(start_n), 32'(rise_obs));
    chk("a_starts", 32'(starts), 32'd1);
    chk("a_errs", 32'(errs), 32'd0);

    // back-to-back conversions
    do_frame(16'h0000, "b0");
    chk("b_code0", 32'(last_code), 32'd0);
    do_frame(16'h1FF8, "b1");
    chk("b_code1023", 32'(last_code), 32'd1023);
    do_frame(16'h1000, "b2");
    chk("b_code512", 32'(last_code), 32'd512);
    do_frame(16'h1528, "b3");
    chk("b_code677", 32'(last_code), 32'd677);
    for (int j = 1; j < 5; j++)
      chk("b_spacing", 32'(falls_q[j] - falls_q[j-1]), 32'(SP));
    for (int j = 0; j < 5; j++)
      chk("b_sclk_rises", 32'(rises_q[j]), 32'd16);

    // bad frame keeps the old code
    s0 = starts;
    e0 = errs;
    do_frame(16'h9528, "c_err");
    chk("c_err_cnt", 32'(errs - e0), 32'd1);
    chk("c_no_start", 32'(starts - s0), 32'd0);
    chk("c_code_held", 32'(code), 32'd677);
    do_frame(16'h0028, "c_good");
    chk("c_code5", 32'(code), 32'd5);

    // reset in the middle of a frame
    frame_q.push_back(16'h1528);
    frame_q.push_back(16'h1528);
    i = 0;
    while (cs_n !== 1'b0 && i < 2 * SP) begin
      tick(1);
      i++;
    end
    i = 0;
    while (sclk_rises < 8 && i < 2 * SP) begin
      tick(1);
      i++;
    end
    chk("d_at_edge8", 32'(sclk_rises >= 8), 32'd1);
    s0 = starts;
    e0 = errs;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("d_cs_n", 32'(cs_n), 32'd1);
    chk("d_sclk", 32'(sclk), 32'd1);
    chk("d_busy", 32'(busy), 32'd0);
    chk("d_code", 32'(code), 32'd0);
    tick(5);
    chk("d_no_strobe", 32'((starts - s0) + (errs - e0)), 32'd0);
    wait_done("d");
    chk("d_restart", 32'(fall_obs - rst_edge), 32'(SP));
    chk("d_code677", 32'(code), 32'd677);

    // enable held low past expiry, then dropped mid-frame
    en = 1'b0;
    frame_q.push_back(16'h0F00);
    fe = fall_obs;
    i = 0;
    while (n < fe + SP + 50 && i < 3 * SP) begin
      tick(1);
      i++;
    end
    chk("e_held", 32'(cs_n), 32'd1);
    en = 1'b1;
    tick(1);
    chk("e_cs_fall", 32'(cs_n), 32'd0);
    s0 = starts;
    tick(20);
    en = 1'b0;
    wait_done("e");
    chk("e_start", 32'(starts - s0), 32'd1);
    chk("e_code", 32'(last_code), 32'd480);
    en = 1'b1;
`endif

    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
